// File: rtl/fb_ram_arbiter_pkg.sv
// rtl/fb_ram_arbiter_pkg.sv - shared defaults, requester/pointer enums and round-robin helpers
//
// Purpose : common definitions for the frame-buffer RAM arbiter.
// Contents: ADDR_W/DATA_W/STARVE_MAX defaults, requester enum, round-robin
//           pointer enum and two small helpers used by the arbiter.
package fb_ram_arbiter_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 15;

  // Requester identity. REQ_NONE marks an idle cycle (no grant).
  typedef enum logic [1:0] {
    REQ_VGA  = 2'd0,
    REQ_LD   = 2'd1,
    REQ_HOST = 2'd2,
    REQ_NONE = 2'd3
  } req_e;

  // Round-robin pointer between the loader and the host.
  typedef enum logic {
    RR_LD   = 1'b0,
    RR_HOST = 1'b1
  } rr_e;

  // Requester preferred by the pointer when loader and host tie.
  function automatic req_e rr_pick(input rr_e ptr);
    return (ptr == RR_LD) ? REQ_LD : REQ_HOST;
  endfunction

  // Pointer moves to the non-winner after a loader/host grant and is left
  // alone after a scanout grant or an idle cycle.
  function automatic rr_e rr_after(input req_e winner, input rr_e cur);
    rr_e nxt;
    nxt = cur;
    if (winner == REQ_LD) begin
      nxt = RR_HOST;
    end else if (winner == REQ_HOST) begin
      nxt = RR_LD;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fb_ram_arbiter_starve_cnt.sv
// rtl/fb_ram_arbiter_starve_cnt.sv - saturating denied-cycle counter for one requester
//
// Purpose : counts consecutive cycles in which a requester asks but is not
//           granted; saturates at MAX and flags when saturated.
// Ports   : clk    - clock, rising edge
//           reset  - synchronous active-high reset, clears the count
//           req    - requester's request
//           gnt    - requester's grant this cycle
//           at_max - count has reached MAX (forces a grant in the arbiter)
module starve_cnt #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic at_max
);

  localparam int CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  logic [CNT_W-1:0] count;

  // A grant or a dropped request ends the starvation episode.
  always_ff @(posedge clk) begin
    if (reset || !req || gnt) begin
      count <= '0;
    end else if (count != MAX_V) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == MAX_V);

endmodule

// File: rtl/fb_ram_arbiter.sv
// rtl/fb_ram_arbiter.sv - three-way single-port RAM arbiter (scanout, loader, host)
//
// Purpose : shares one synchronous RAM port between a scanout reader, a
//           loader writer and a host reader. Priority: starvation-forced
//           grant, then scanout, then round-robin loader/host.
// Ports   : clk, reset                     - clock, sync active-high reset
//           vga_req/addr, vga_gnt          - scanout read request/grant
//           vga_rvalid/rdata               - scanout read return
//           ld_req/addr/wdata, ld_gnt      - loader write request/grant
//           host_req/addr, host_gnt        - host read request/grant
//           host_rvalid/rdata              - host read return
//           ram_we/addr/wdata, ram_rdata   - RAM port (1-cycle read latency)
module fb_ram_arbiter
  import fb_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  logic              ld_at_max;
  logic              host_at_max;
  logic              force_ld;
  logic              force_host;
  req_e              winner;
  rr_e               rr_q;
  rr_e               rr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              vga_rv_q;
  logic              host_rv_q;

  starve_cnt #(.MAX(STARVE_MAX)) u_starve_ld (
    .clk    (clk),
    .reset  (reset),
    .req    (ld_req),
    .gnt    (ld_gnt),
    .at_max (ld_at_max)
  );

  starve_cnt #(.MAX(STARVE_MAX)) u_starve_host (
    .clk    (clk),
    .reset  (reset),
    .req    (host_req),
    .gnt    (host_gnt),
    .at_max (host_at_max)
  );

  assign force_ld   = ld_req   && ld_at_max;
  assign force_host = host_req && host_at_max;

  // Winner selection. Reset suppresses every grant so nothing reaches the RAM.
  always_comb begin
    winner = REQ_NONE;
    if (reset) begin
      winner = REQ_NONE;
    end else if (force_ld && force_host) begin
      winner = rr_pick(rr_q);
    end else if (force_ld) begin
      winner = REQ_LD;
    end else if (force_host) begin
      winner = REQ_HOST;
    end else if (vga_req) begin
      winner = REQ_VGA;
    end else if (ld_req && host_req) begin
      winner = rr_pick(rr_q);
    end else if (ld_req) begin
      winner = REQ_LD;
    end else if (host_req) begin
      winner = REQ_HOST;
    end
  end

  assign vga_gnt  = (winner == REQ_VGA);
  assign ld_gnt   = (winner == REQ_LD);
  assign host_gnt = (winner == REQ_HOST);

  // Round-robin pointer: state register plus next-state logic.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= RR_LD;
    end else begin
      rr_q <= rr_d;
    end
  end

  always_comb begin
    rr_d = rr_q;
    rr_d = rr_after(winner, rr_q);
  end

  // RAM port: winner's address passes straight through; idle cycles replay
  // the last address/data from the hold registers so the bus never toggles.
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_we    = 1'b0;
    case (winner)
      REQ_VGA:  ram_addr = vga_addr;
      REQ_HOST: ram_addr = host_addr;
      REQ_LD: begin
        ram_addr  = ld_addr;
        ram_wdata = ld_wdata;
        ram_we    = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
    end
  end

  // Read returns: RAM data appears one cycle after the grant. The valid flag
  // is also masked by reset so a read granted just before reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rv_q  <= 1'b0;
      host_rv_q <= 1'b0;
    end else begin
      vga_rv_q  <= vga_gnt;
      host_rv_q <= host_gnt;
    end
  end

  assign vga_rvalid  = vga_rv_q  && !reset;
  assign host_rvalid = host_rv_q && !reset;
  assign vga_rdata   = ram_rdata;
  assign host_rdata  = ram_rdata;

endmodule

// File: doc/fb_ram_arbiter.md
FB_RAM_ARBITER -- requirements
Module: fb_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the RAM address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the RAM data width in bits.
REQ-003 The block SHALL have parameter STARVE_MAX, default 15, giving the number of consecutive denied cycles before a forced grant.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port vga_req, input, 1 bit: scanout read request.
REQ-007 Port vga_addr, input, ADDR_W bits: scanout read address.
REQ-008 Port vga_gnt, output, 1 bit: scanout read issued this cycle.
REQ-009 Port vga_rvalid, output, 1 bit: vga_rdata valid.
REQ-010 Port vga_rdata, output, DATA_W bits: scanout read data.
REQ-011 Port ld_req, input, 1 bit: loader (ROM-to-RAM copy) write request.
REQ-012 Port ld_addr, input, ADDR_W bits: loader write address.
REQ-013 Port ld_wdata, input, DATA_W bits: loader write data.
REQ-014 Port ld_gnt, output, 1 bit: loader write issued this cycle.
REQ-015 Port host_req, input, 1 bit: host read request.
REQ-016 Port host_addr, input, ADDR_W bits: host read address.
REQ-017 Port host_gnt, output, 1 bit: host read issued this cycle.
REQ-018 Port host_rvalid, output, 1 bit: host_rdata valid.
REQ-019 Port host_rdata, output, DATA_W bits: host read data.
REQ-020 Port ram_we, output, 1 bit: RAM write enable.
REQ-021 Port ram_addr, output, ADDR_W bits: RAM address.
REQ-022 Port ram_wdata, output, DATA_W bits: RAM write data.
REQ-023 Port ram_rdata, input, DATA_W bits: RAM read data, valid one cycle after the address is presented.

Function
REQ-024 At most one of vga_gnt, ld_gnt and host_gnt SHALL be high in any cycle.
REQ-025 Each gnt SHALL be a combinational function of the reqs and registered state; a requester SHALL hold req and its address/data stable until it sees gnt.
REQ-026 Priority SHALL be: forced grant first, then vga_req, then round-robin between ld_req and host_req.
REQ-027 The round-robin pointer SHALL flip to the non-winner after each ld or host grant, and SHALL be unchanged on a vga grant or an idle cycle.
REQ-028 Counters starve_ld and starve_host SHALL each increment while their req is high and gnt is low, clear on grant or when req drops, and saturate at STARVE_MAX.
REQ-029 A counter at STARVE_MAX SHALL force a grant to its requester over vga_req; if both counters are at STARVE_MAX, the round-robin pointer SHALL pick the winner.
REQ-030 On any grant, ram_addr SHALL equal the winner's address in the same cycle; ram_we SHALL be 1 only for ld_gnt, with ram_wdata = ld_wdata.
REQ-031 With no grant, ram_we SHALL be 0 and ram_addr/ram_wdata SHALL hold their last values (registered hold, no toggling).
REQ-032 vga_rvalid or host_rvalid SHALL be high exactly one cycle after the corresponding gnt, with its rdata equal to ram_rdata in that cycle.
REQ-033 A read granted in the cycle immediately after a loader write to the same address SHALL return the new data.
REQ-034 Back-to-back grants to the same requester SHALL be allowed, giving full throughput of one access per cycle.

Reset
REQ-035 While reset is high, all gnt, rvalid and ram_we SHALL be 0, counters SHALL be 0, the pointer SHALL select ld, ram_addr SHALL be 0, and any in-flight rvalid SHALL be discarded.
REQ-036 The first cycle after reset is released SHALL arbitrate normally.

Structure
REQ-037 A shared package SHALL hold ADDR_W/DATA_W defaults and a requester enum (REQ_VGA, REQ_LD, REQ_HOST).
REQ-038 Starvation counting SHALL live in a single reusable sub-module, starve_cnt, instantiated twice.

Verification
REQ-039 Only ld_req is active, writing addr 1..3 with data 10,20,30 -> ld_gnt is high 3 consecutive cycles and ram_we is high for each write.
REQ-040 ld_req and host_req are both held continuously -> grants alternate ld, host, ld, host, starting with ld after reset.
REQ-041 vga_req is held continuously with ld_req -> ld_gnt is forced on the 16th cycle and the vga grant resumes the next cycle.
REQ-042 A host read of addr 2 is issued the cycle after a loader write of 0xDEAD to addr 2 -> host_rvalid is high one cycle later with host_rdata = 0xDEAD.
REQ-043 Reset is asserted in the cycle after vga_gnt -> vga_rvalid stays 0 and all counters read 0.
